// File: rtl/laser310_bank_ctrl.sv
// Laser 310 64K expansion bank-select register: synchronizes the Z80 bus,
// filters I/O writes to port group 7xh and latches D1..D0 as the RAM bank.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no write in progress, waiting for the first valid sample
//   QUAL     | counting consecutive valid samples up to FILTER_LEN
//   WAIT_END | bank captured, waiting for FILTER_LEN release samples
module laser310_bank_ctrl #(
  parameter int          FILTER_LEN = 2,
  parameter logic [1:0]  RESET_BANK = 2'b01
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] AddrIO,
  input  logic [1:0] D1D0,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       MREQ_N,
  input  logic       IORQ_N,
  output logic [1:0] bank,
  output logic       bank_wr,
  output logic       io_active,
  output logic [7:0] wr_count
);

  typedef enum logic [1:0] {IDLE, QUAL, WAIT_END} state_t;

  localparam logic [3:0] FL = 4'(FILTER_LEN);
  // Bus order: AddrIO, D1D0, WR_N, RD_N, MREQ_N, IORQ_N
  localparam logic [9:0] BUS_IDLE = {4'b0000, 2'b00, 4'b1111};

  logic [9:0] s1, s2;
  logic [3:0] s2_addr;
  logic [1:0] s2_data;
  logic       s2_wr_n, s2_rd_n, s2_mreq_n, s2_iorq_n;
  logic       v, rel;

  state_t     state, state_n;
  logic [3:0] q, q_n, r, r_n;
  logic       capture;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= BUS_IDLE;
      s2 <= BUS_IDLE;
    end else begin
      s1 <= {AddrIO, D1D0, WR_N, RD_N, MREQ_N, IORQ_N};
      s2 <= s1;
    end
  end

  assign {s2_addr, s2_data, s2_wr_n, s2_rd_n, s2_mreq_n, s2_iorq_n} = s2;

  // Conflicting strobes (MREQ with IORQ, RD with WR) never qualify.
  assign v   = !s2_iorq_n && s2_mreq_n && !s2_wr_n && s2_rd_n && (s2_addr == 4'b0111);
  assign rel = s2_iorq_n || s2_wr_n;

  always_comb begin
    state_n = state;
    q_n     = q;
    r_n     = r;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (v) begin
          q_n = 4'd1;
          if (FL == 4'd1) begin
            capture = 1'b1;
            r_n     = 4'd0;
            state_n = WAIT_END;
          end else begin
            state_n = QUAL;
          end
        end else begin
          q_n = 4'd0;
        end
      end
      QUAL: begin
        if (v) begin
          if (q + 4'd1 == FL) begin
            capture = 1'b1;
            q_n     = 4'd0;
            r_n     = 4'd0;
            state_n = WAIT_END;
          end else begin
            q_n = q + 4'd1;
          end
        end else begin
          q_n     = 4'd0;
          state_n = IDLE;
        end
      end
      WAIT_END: begin
        if (rel) begin
          if (r + 4'd1 == FL) begin
            r_n     = 4'd0;
            state_n = IDLE;
          end else begin
            r_n = r + 4'd1;
          end
        end else begin
          r_n = 4'd0;
        end
      end
      default: begin
        q_n     = 4'd0;
        r_n     = 4'd0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      q         <= 4'd0;
      r         <= 4'd0;
      bank      <= RESET_BANK;
      bank_wr   <= 1'b0;
      io_active <= 1'b0;
      wr_count  <= 8'd0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      r         <= r_n;
      bank_wr   <= capture;
      io_active <= (state_n != IDLE);
      if (capture) begin
        bank     <= s2_data;
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule
